// File: rtl/gray_ptr_fifo_ctrl_pkg.sv
// Shared types for the Gray-pointer FIFO controller.
//   op_t : classifies what a cycle does to the FIFO occupancy, used to
//          select the next fill level.
package gray_ptr_fifo_ctrl_pkg;

  typedef enum logic [1:0] {
    OP_IDLE  = 2'b00,
    OP_READ  = 2'b01,
    OP_WRITE = 2'b10,
    OP_BOTH  = 2'b11
  } op_t;

endpackage

// File: rtl/bin2gray.sv
// Combinational binary-to-Gray converter.
//   bin  : binary input, WIDTH bits
//   gray : Gray-coded output, WIDTH bits
module bin2gray #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] bin,
  output logic [WIDTH-1:0] gray
);

  assign gray = bin ^ (bin >> 1);

endmodule

// File: rtl/gray_ptr_fifo_ctrl.sv
// FIFO pointer/flag controller with Gray-coded pointer outputs.
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   w_req, r_req        : write / read requests
//   w_en, r_en          : RAM strobes (request qualified by current full/empty)
//   w_addr, r_addr      : RAM addresses (low bits of the binary pointers)
//   w_ptr_gray,
//   r_ptr_gray          : registered Gray pointers (zero when USE_GRAY_OUT=0)
//   cnt                 : registered fill level, 0..2**DEPTH_W
//   full, empty         : registered flags, consistent with cnt
//   ovf, unf            : one-cycle pulses after a rejected write / read
// Handshake: a request is accepted in the cycle it is presented if and only
// if the matching strobe (w_en / r_en) is high; there is no back-pressure
// other than full/empty and no request is held over to a later cycle.
module gray_ptr_fifo_ctrl
  import gray_ptr_fifo_ctrl_pkg::*;
#(
  parameter int DEPTH_W      = 4,
  parameter bit USE_GRAY_OUT = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               w_req,
  input  logic               r_req,
  output logic               w_en,
  output logic               r_en,
  output logic [DEPTH_W-1:0] w_addr,
  output logic [DEPTH_W-1:0] r_addr,
  output logic [DEPTH_W:0]   w_ptr_gray,
  output logic [DEPTH_W:0]   r_ptr_gray,
  output logic [DEPTH_W:0]   cnt,
  output logic               full,
  output logic               empty,
  output logic               ovf,
  output logic               unf
);

  localparam int PW = DEPTH_W + 1;
  localparam logic [PW-1:0] FULL_CNT = {1'b1, {DEPTH_W{1'b0}}};
  localparam logic [PW-1:0] ONE      = {{DEPTH_W{1'b0}}, 1'b1};

  logic [PW-1:0] w_ptr, r_ptr;
  logic [PW-1:0] w_ptr_next, r_ptr_next;
  logic [PW-1:0] cnt_next;
  op_t           op;

  // Acceptance uses the registered flags of this cycle; reset masks both.
  assign w_en = w_req & ~full  & ~rst;
  assign r_en = r_req & ~empty & ~rst;

  assign w_addr = w_ptr[DEPTH_W-1:0];
  assign r_addr = r_ptr[DEPTH_W-1:0];

  assign op = op_t'({w_en, r_en});

  always_comb begin
    w_ptr_next = w_en ? w_ptr + ONE : w_ptr;
    r_ptr_next = r_en ? r_ptr + ONE : r_ptr;
    cnt_next   = cnt;
    case (op)
      OP_WRITE: cnt_next = cnt + ONE;
      OP_READ:  cnt_next = cnt - ONE;
      default:  cnt_next = cnt;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      w_ptr <= '0;
      r_ptr <= '0;
      cnt   <= '0;
      full  <= 1'b0;
      empty <= 1'b1;
      ovf   <= 1'b0;
      unf   <= 1'b0;
    end else begin
      w_ptr <= w_ptr_next;
      r_ptr <= r_ptr_next;
      cnt   <= cnt_next;
      // Flags come from the next count so they line up with the new cnt.
      full  <= (cnt_next == FULL_CNT);
      empty <= (cnt_next == '0);
      ovf   <= w_req & full;
      unf   <= r_req & empty;
    end
  end

  generate
    if (USE_GRAY_OUT) begin : g_gray
      logic [PW-1:0] w_gray_next, r_gray_next;
      logic [PW-1:0] w_gray_q, r_gray_q;
      // A full FIFO differs from empty only in the wrap bit of the binary
      // pointers, which in Gray code shows up as the top two bits inverted.
      localparam logic [PW-1:0] TOP2_MASK = {2'b11, {(PW-2){1'b0}}};

      bin2gray #(.WIDTH(PW)) u_w_gray (.bin(w_ptr_next), .gray(w_gray_next));
      bin2gray #(.WIDTH(PW)) u_r_gray (.bin(r_ptr_next), .gray(r_gray_next));

      always_ff @(posedge clk) begin
        if (rst) begin
          w_gray_q <= '0;
          r_gray_q <= '0;
        end else begin
          w_gray_q <= w_gray_next;
          r_gray_q <= r_gray_next;
        end
      end

      assign w_ptr_gray = w_gray_q;
      assign r_ptr_gray = r_gray_q;

      a_full_gray: assert property (@(posedge clk) disable iff (rst)
        full == (w_gray_q == (r_gray_q ^ TOP2_MASK)));
      a_empty_gray: assert property (@(posedge clk) disable iff (rst)
        empty == (w_gray_q == r_gray_q));
    end else begin : g_no_gray
      assign w_ptr_gray = '0;
      assign r_ptr_gray = '0;
    end
  endgenerate

endmodule

// File: tb/tb_gray_ptr_fifo_ctrl.sv
// Self-checking bench for gray_ptr_fifo_ctrl at DEPTH_W=2.
module tb_gray_ptr_fifo_ctrl;

  localparam int DW    = 2;
  localparam int DEPTH = 4;
  localparam int W     = DW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          w_req = 1'b0;
  logic          r_req = 1'b0;
  logic          w_en, r_en;
  logic [DW-1:0] w_addr, r_addr;
  logic [DW:0]   w_ptr_gray, r_ptr_gray, cnt;
  logic          full, empty, ovf, unf;

  int checks = 0;
  int errors = 0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish (got running, exp finished)");
    $fatal(1, "timeout");
  end

  gray_ptr_fifo_ctrl #(.DEPTH_W(DW), .USE_GRAY_OUT(1)) dut (
    .clk(clk), .rst(rst), .w_req(w_req), .r_req(r_req),
    .w_en(w_en), .r_en(r_en), .w_addr(w_addr), .r_addr(r_addr),
    .w_ptr_gray(w_ptr_gray), .r_ptr_gray(r_ptr_gray), .cnt(cnt),
    .full(full), .empty(empty), .ovf(ovf), .unf(unf)
  );

  // ---------------- reference model ----------------
  // Occupancy is a queue of RAM slots written but not yet read; pointers are
  // plain running totals of accepted writes/reads modulo 2*DEPTH.
  logic [W-1:0] exp_q[$];
  int   m_wr = 0, m_rd = 0;
  logic m_ovf = 0, m_unf = 0;

  // values captured before the clock edge of the last drive() call
  logic obs_w_en, obs_r_en, exp_w_en, exp_r_en;
  logic [DW-1:0] obs_w_addr, obs_r_addr, exp_w_addr, exp_r_addr;
  logic          slot_valid;
  logic [W-1:0]  exp_slot;

  function automatic logic [DW:0] to_gray(input int b);
    logic [DW:0] v;
    v = b[DW:0];
    return v ^ (v >> 1);
  endfunction

  function automatic int m_cnt();
    return exp_q.size();
  endfunction

  // ---------------- driver ----------------
  task automatic drive(input logic w, input logic r, input logic rs);
    logic was_full, was_empty, wacc, racc;
    w_req = w; r_req = r; rst = rs;
    #1;
    obs_w_en = w_en; obs_r_en = r_en;
    obs_w_addr = w_addr; obs_r_addr = r_addr;
    was_full  = (exp_q.size() == DEPTH);
    was_empty = (exp_q.size() == 0);
    exp_w_en  = w && !rs && !was_full;
    exp_r_en  = r && !rs && !was_empty;
    exp_w_addr = m_wr[DW-1:0];
    exp_r_addr = m_rd[DW-1:0];
    slot_valid = exp_r_en;
    exp_slot   = was_empty ? '0 : exp_q[0];
    @(posedge clk);
    #1;
    if (rs) begin
      exp_q.delete();
      m_wr = 0; m_rd = 0; m_ovf = 0; m_unf = 0;
    end else begin
      wacc = w && !was_full;
      racc = r && !was_empty;
      m_ovf = w && was_full;
      m_unf = r && was_empty;
      if (racc) begin
        void'(exp_q.pop_front());
        m_rd = (m_rd + 1) % (2 * DEPTH);
      end
      if (wacc) begin
        exp_q.push_back(m_wr[W-1:0]);
        m_wr = (m_wr + 1) % (2 * DEPTH);
      end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    drive(0, 0, 1);
    drive(1, 1, 1);
    checks++; if (obs_w_en !== 1'b0 || obs_r_en !== 1'b0) begin
      errors++; $display("FAIL reset_strobes: got w_en=%0b r_en=%0b exp 0 0", obs_w_en, obs_r_en);
    end
    checks++; if (cnt !== 3'd0 || empty !== 1'b1 || full !== 1'b0) begin
      errors++; $display("FAIL reset_state: got cnt=%0d empty=%0b full=%0b exp 0 1 0", cnt, empty, full);
    end
    checks++; if (w_ptr_gray !== 3'd0 || r_ptr_gray !== 3'd0 || ovf !== 1'b0 || unf !== 1'b0) begin
      errors++; $display("FAIL reset_gray_pulses: got wg=%0b rg=%0b ovf=%0b unf=%0b exp 0 0 0 0",
                         w_ptr_gray, r_ptr_gray, ovf, unf);
    end
  endtask

  task automatic test_fill();
    logic [DW:0] gray_tbl[4];
    gray_tbl[0] = 3'b001; gray_tbl[1] = 3'b011; gray_tbl[2] = 3'b010; gray_tbl[3] = 3'b110;
    drive(0, 0, 1);
    for (int i = 0; i < 4; i++) begin
      drive(1, 0, 0);
      checks++; if (obs_w_en !== 1'b1 || obs_w_addr !== exp_w_addr) begin
        errors++; $display("FAIL fill_w_en[%0d]: got w_en=%0b addr=%0d exp 1 %0d", i, obs_w_en, obs_w_addr, exp_w_addr);
      end
      checks++; if (cnt !== 3'(i + 1)) begin
        errors++; $display("FAIL fill_cnt[%0d]: got %0d exp %0d", i, cnt, i + 1);
      end
      checks++; if (w_ptr_gray !== gray_tbl[i]) begin
        errors++; $display("FAIL fill_gray[%0d]: got %b exp %b", i, w_ptr_gray, gray_tbl[i]);
      end
      checks++; if (full !== (i == 3)) begin
        errors++; $display("FAIL fill_full[%0d]: got %0b exp %0b", i, full, (i == 3));
      end
    end
  endtask

  task automatic test_overflow();
    drive(1, 0, 0);  // FIFO is full from test_fill
    checks++; if (obs_w_en !== 1'b0) begin
      errors++; $display("FAIL ovf_w_en: got %0b exp 0", obs_w_en);
    end
    checks++; if (ovf !== 1'b1 || cnt !== 3'd4 || full !== 1'b1) begin
      errors++; $display("FAIL ovf_pulse: got ovf=%0b cnt=%0d full=%0b exp 1 4 1", ovf, cnt, full);
    end
    drive(0, 0, 0);
    checks++; if (ovf !== 1'b0) begin
      errors++; $display("FAIL ovf_one_cycle: got %0b exp 0", ovf);
    end
  endtask

  task automatic test_full_both();
    drive(1, 1, 0);
    checks++; if (obs_w_en !== 1'b0 || obs_r_en !== 1'b1) begin
      errors++; $display("FAIL full_both_strobes: got w_en=%0b r_en=%0b exp 0 1", obs_w_en, obs_r_en);
    end
    checks++; if (cnt !== 3'd3 || ovf !== 1'b1 || full !== 1'b0) begin
      errors++; $display("FAIL full_both_state: got cnt=%0d ovf=%0b full=%0b exp 3 1 0", cnt, ovf, full);
    end
    drive(0, 0, 0);
    checks++; if (ovf !== 1'b0) begin
      errors++; $display("FAIL full_both_ovf_clear: got %0b exp 0", ovf);
    end
  endtask

  task automatic test_empty_both();
    drive(0, 0, 1);
    drive(1, 1, 0);
    checks++; if (obs_w_en !== 1'b1 || obs_r_en !== 1'b0) begin
      errors++; $display("FAIL empty_both_strobes: got w_en=%0b r_en=%0b exp 1 0", obs_w_en, obs_r_en);
    end
    checks++; if (cnt !== 3'd1 || unf !== 1'b1 || empty !== 1'b0) begin
      errors++; $display("FAIL empty_both_state: got cnt=%0d unf=%0b empty=%0b exp 1 1 0", cnt, unf, empty);
    end
    drive(0, 0, 0);
    checks++; if (unf !== 1'b0) begin
      errors++; $display("FAIL empty_both_unf_clear: got %0b exp 0", unf);
    end
  endtask

  task automatic test_back_to_back();
    logic [DW:0] pw, pr;
    int wraps_w, wraps_r;
    drive(0, 0, 1);
    drive(1, 0, 0);
    drive(1, 0, 0);
    pw = w_ptr_gray; pr = r_ptr_gray;
    wraps_w = 0; wraps_r = 0;
    for (int i = 0; i < 16; i++) begin
      drive(1, 1, 0);
      checks++; if (cnt !== 3'd2 || $countones(w_ptr_gray ^ pw) != 1 || $countones(r_ptr_gray ^ pr) != 1) begin
        errors++; $display("FAIL b2b_step[%0d]: got cnt=%0d wg %b->%b rg %b->%b exp cnt 2, one-bit steps",
                           i, cnt, pw, w_ptr_gray, pr, r_ptr_gray);
      end
      if (w_ptr_gray == 3'd0) wraps_w++;
      if (r_ptr_gray == 3'd0) wraps_r++;
      pw = w_ptr_gray; pr = r_ptr_gray;
    end
    checks++; if (wraps_w != 2 || wraps_r != 2) begin
      errors++; $display("FAIL b2b_wraps: got w=%0d r=%0d exp 2 2", wraps_w, wraps_r);
    end
  endtask

  task automatic test_reset_mid();
    drive(0, 0, 1);
    for (int i = 0; i < 3; i++) drive(1, 0, 0);
    drive(1, 1, 1);
    checks++; if (cnt !== 3'd0 || empty !== 1'b1 || w_ptr_gray !== 3'd0 || r_ptr_gray !== 3'd0) begin
      errors++; $display("FAIL reset_mid_state: got cnt=%0d empty=%0b wg=%b rg=%b exp 0 1 000 000",
                         cnt, empty, w_ptr_gray, r_ptr_gray);
    end
    checks++; if (ovf !== 1'b0 || unf !== 1'b0 || obs_w_en !== 1'b0 || obs_r_en !== 1'b0) begin
      errors++; $display("FAIL reset_mid_pulses: got ovf=%0b unf=%0b w_en=%0b r_en=%0b exp 0 0 0 0",
                         ovf, unf, obs_w_en, obs_r_en);
    end
    // reset while full, with a write pending
    for (int i = 0; i < 4; i++) drive(1, 0, 0);
    drive(1, 0, 1);
    checks++; if (ovf !== 1'b0 || cnt !== 3'd0 || full !== 1'b0) begin
      errors++; $display("FAIL reset_full: got ovf=%0b cnt=%0d full=%0b exp 0 0 0", ovf, cnt, full);
    end
    drive(1, 0, 0);
    checks++; if (obs_w_en !== 1'b1 || cnt !== 3'd1) begin
      errors++; $display("FAIL first_after_reset: got w_en=%0b cnt=%0d exp 1 1", obs_w_en, cnt);
    end
  endtask

  task automatic test_random();
    logic w, r, rs;
    for (int i = 0; i < 400; i++) begin
      w  = ($urandom_range(0, 99) < 55);
      r  = ($urandom_range(0, 99) < 45);
      rs = ($urandom_range(0, 63) == 0);
      drive(w, r, rs);
      checks++; if (obs_w_en !== exp_w_en || obs_r_en !== exp_r_en) begin
        errors++; $display("FAIL rnd_strobes[%0d]: got %0b%0b exp %0b%0b", i, obs_w_en, obs_r_en, exp_w_en, exp_r_en);
      end
      checks++; if (obs_w_addr !== exp_w_addr || obs_r_addr !== exp_r_addr) begin
        errors++; $display("FAIL rnd_addr[%0d]: got w=%0d r=%0d exp w=%0d r=%0d",
                           i, obs_w_addr, obs_r_addr, exp_w_addr, exp_r_addr);
      end
      if (slot_valid) begin
        checks++; if (obs_r_addr !== exp_slot) begin
          errors++; $display("FAIL rnd_read_slot[%0d]: got %0d exp %0d", i, obs_r_addr, exp_slot);
        end
      end
      checks++; if (cnt !== 3'(m_cnt()) || full !== (m_cnt() == DEPTH) || empty !== (m_cnt() == 0)) begin
        errors++; $display("FAIL rnd_level[%0d]: got cnt=%0d full=%0b empty=%0b exp cnt=%0d",
                           i, cnt, full, empty, m_cnt());
      end
      checks++; if (ovf !== m_ovf || unf !== m_unf) begin
        errors++; $display("FAIL rnd_pulses[%0d]: got ovf=%0b unf=%0b exp %0b %0b", i, ovf, unf, m_ovf, m_unf);
      end
      checks++; if (w_ptr_gray !== to_gray(m_wr) || r_ptr_gray !== to_gray(m_rd)) begin
        errors++; $display("FAIL rnd_gray[%0d]: got wg=%b rg=%b exp %b %b",
                           i, w_ptr_gray, r_ptr_gray, to_gray(m_wr), to_gray(m_rd));
      end
    end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    @(posedge clk);
    #1;
    test_reset();
    test_fill();
    test_overflow();
    test_full_both();
    test_empty_both();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
